dpram_port_arbiter: RTL and testbench

Shares the two ports of the team's dual_port_ram (synchronous, 1-cycle read) between NUM_REQ independent requesters. Each cycle it grants up to two requests, one per RAM port, in round-robin order, and defers address-conflicting pairs. It tags each read and returns data to the originating requester. It sits between client engines and one dual_port_ram instance and drives that RAM's ports directly.

---
 rtl/dpram_arb_pkg.sv | 11 +
 rtl/dpram_port_arbiter_rr_pick2.sv | 31 +++
 rtl/dpram_port_arbiter.sv | 106 ++++++++++
 tb/tb_dpram_port_arbiter.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/dpram_arb_pkg.sv
// dpram_arb_pkg: default widths and requester-index sizing shared by the dual-port RAM arbiter.
package dpram_arb_pkg;
   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_ADDR_WIDTH = 4;
   localparam int DEF_NUM_REQ    = 4;
   localparam int DEF_CNT_WIDTH  = 16;
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
   localparam int DEF_IDX_WIDTH = idx_width(DEF_NUM_REQ);
endpackage

// File: rtl/dpram_port_arbiter_rr_pick2.sv
// rr_pick2: finds the first two set bits of a valid vector, scanning circularly from ptr.
module rr_pick2 #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  valid,
   input  logic [IW-1:0] ptr,
   output logic [IW-1:0] idx_a,
   output logic [IW-1:0] idx_b,
   output logic          found_a,
   output logic          found_b
);
   logic [IW-1:0] j;
   always_comb begin
      j       = '0;
      idx_a   = '0;
      idx_b   = '0;
      found_a = 1'b0;
      found_b = 1'b0;
      for (int k = 0; k < N; k++) begin
         j = IW'((int'(ptr) + k) % N);
         if (valid[j] && !found_a) begin
            found_a = 1'b1;
            idx_a   = j;
         end else if (valid[j] && !found_b) begin
            found_b = 1'b1;
            idx_b   = j;
         end
      end
   end
endmodule

// File: rtl/dpram_port_arbiter.sv
// dpram_port_arbiter: round-robin sharing of a dual-port RAM between NUM_REQ requesters,
// deferring address-conflicting pairs and routing 1-cycle read data back to its requester.
module dpram_port_arbiter
   import dpram_arb_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int NUM_REQ    = DEF_NUM_REQ,
   parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [NUM_REQ-1:0]               req_valid,
   output logic [NUM_REQ-1:0]               req_ready,
   input  logic [NUM_REQ-1:0]               req_we,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
   output logic [NUM_REQ-1:0]               rsp_valid,
   output logic [NUM_REQ*DATA_WIDTH-1:0]    rsp_data,
   output logic                             ram_we_a,
   output logic                             ram_we_b,
   output logic [ADDR_WIDTH-1:0]            ram_addr_a,
   output logic [ADDR_WIDTH-1:0]            ram_addr_b,
   output logic [DATA_WIDTH-1:0]            ram_din_a,
   output logic [DATA_WIDTH-1:0]            ram_din_b,
   input  logic [DATA_WIDTH-1:0]            ram_dout_a,
   input  logic [DATA_WIDTH-1:0]            ram_dout_b,
   output logic [CNT_WIDTH-1:0]             conflict_cnt
);
   localparam int IW = idx_width(NUM_REQ);
   logic [ADDR_WIDTH-1:0]         addr_u  [NUM_REQ];
   logic [DATA_WIDTH-1:0]         wdata_u [NUM_REQ];
   logic [IW-1:0]                 rr_ptr, idx_a, idx_b, tag_ia, tag_ib, last, ptr_next;
   logic                          found_a, found_b, tag_va, tag_vb, conflict, grant_a, grant_b;
   logic [NUM_REQ*DATA_WIDTH-1:0] held;

   genvar i;
   for (i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign addr_u[i]  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      assign wdata_u[i] = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
   end

   rr_pick2 #(.N(NUM_REQ), .IW(IW)) u_pick (
      .valid   (req_valid),
      .ptr     (rr_ptr),
      .idx_a   (idx_a),
      .idx_b   (idx_b),
      .found_a (found_a),
      .found_b (found_b)
   );

   assign conflict = found_b && (addr_u[idx_a] == addr_u[idx_b]) && (req_we[idx_a] || req_we[idx_b]);
   assign grant_a  = rst_n && found_a;
   assign grant_b  = rst_n && found_b && !conflict;
   assign last     = grant_b ? idx_b : idx_a;
   assign ptr_next = (last == IW'(NUM_REQ - 1)) ? '0 : last + 1'b1;

   assign ram_we_a   = grant_a && req_we[idx_a];
   assign ram_addr_a = grant_a ? addr_u[idx_a]  : '0;
   assign ram_din_a  = grant_a ? wdata_u[idx_a] : '0;
   assign ram_we_b   = grant_b && req_we[idx_b];
   assign ram_addr_b = grant_b ? addr_u[idx_b]  : '0;
   assign ram_din_b  = grant_b ? wdata_u[idx_b] : '0;

   always_comb begin
      req_ready = '0;
      if (grant_a) req_ready[idx_a] = 1'b1;
      if (grant_b) req_ready[idx_b] = 1'b1;
   end

   // Responses line up with the RAM's registered output, so the tagged slot shows dout directly.
   always_comb begin
      rsp_valid = '0;
      rsp_data  = held;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (tag_va && tag_ia == IW'(k)) begin
            rsp_valid[k]                         = 1'b1;
            rsp_data[k*DATA_WIDTH +: DATA_WIDTH] = ram_dout_a;
         end
         if (tag_vb && tag_ib == IW'(k)) begin
            rsp_valid[k]                         = 1'b1;
            rsp_data[k*DATA_WIDTH +: DATA_WIDTH] = ram_dout_b;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr       <= '0;
         tag_va       <= 1'b0;
         tag_vb       <= 1'b0;
         tag_ia       <= '0;
         tag_ib       <= '0;
         held         <= '0;
         conflict_cnt <= '0;
      end else begin
         held   <= rsp_data;
         tag_va <= grant_a && !req_we[idx_a];
         tag_vb <= grant_b && !req_we[idx_b];
         tag_ia <= idx_a;
         tag_ib <= idx_b;
         if (grant_a) rr_ptr <= ptr_next;
         if (conflict && !(&conflict_cnt)) conflict_cnt <= conflict_cnt + 1'b1;
      end
   end
endmodule

// File: tb/tb_dpram_port_arbiter.sv
// tb_dpram_port_arbiter: directed checks of grants, RAM drive, read return, rotation,
// reset drop and counter saturation against a behavioural dual-port RAM.
module tb_dpram_port_arbiter;
   localparam int DW = 8, AW = 4, NR = 4, CW = 4;
   logic          clk = 1'b0, rst_n = 1'b1;
   logic [NR-1:0] req_valid, req_ready, req_we, rsp_valid;
   logic [NR*AW-1:0] req_addr;
   logic [NR*DW-1:0] req_wdata, rsp_data;
   logic          ram_we_a, ram_we_b;
   logic [AW-1:0] ram_addr_a, ram_addr_b;
   logic [DW-1:0] ram_din_a, ram_din_b, ram_dout_a, ram_dout_b;
   logic [CW-1:0] conflict_cnt;
   logic [DW-1:0] mem [2**AW];
   int checks = 0, errors = 0;

   dpram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(NR), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .ram_we_a(ram_we_a), .ram_we_b(ram_we_b), .ram_addr_a(ram_addr_a), .ram_addr_b(ram_addr_b),
      .ram_din_a(ram_din_a), .ram_din_b(ram_din_b), .ram_dout_a(ram_dout_a), .ram_dout_b(ram_dout_b),
      .conflict_cnt(conflict_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_we_a) mem[ram_addr_a] <= ram_din_a;
      if (ram_we_b) mem[ram_addr_b] <= ram_din_b;
      ram_dout_a <= mem[ram_addr_a];
      ram_dout_b <= mem[ram_addr_b];
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
   endtask

   task automatic set_req(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_valid[i] = 1'b1; req_we[i] = w;
      req_addr[i*AW +: AW] = a; req_wdata[i*DW +: DW] = d;
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   function automatic logic [DW-1:0] rd(input int i);
      return rsp_data[i*DW +: DW];
   endfunction

   initial begin
      for (int k = 0; k < 2**AW; k++) mem[k] = '0;
      idle();
      #2 rst_n = 1'b0;
      req_valid = 4'hF; req_we = 4'hF;
      #1;
      chk("rst_ready", req_ready, 4'h0);
      chk("rst_we_a", ram_we_a, 1'b0);
      chk("rst_we_b", ram_we_b, 1'b0);
      chk("rst_rsp_valid", rsp_valid, 4'h0);
      chk("rst_rsp_data", rsp_data, 32'h0);
      chk("rst_cnt", conflict_cnt, 4'h0);
      tick(); tick();
      idle(); rst_n = 1'b1; #1;
      chk("idle_ready", req_ready, 4'h0);
      chk("idle_we_a", ram_we_a, 1'b0);
      chk("idle_we_b", ram_we_b, 1'b0);
      chk("idle_rsp_valid", rsp_valid, 4'h0);
      tick();
      chk("idle_cnt", conflict_cnt, 4'h0);
      // two writes on both ports
      set_req(0, 1'b1, 4'd3, 8'hA5); set_req(1, 1'b1, 4'd7, 8'h5A); #1;
      chk("wr_ready", req_ready, 4'b0011);
      chk("wr_port_a", {ram_we_a, ram_addr_a, ram_din_a}, {1'b1, 4'd3, 8'hA5});
      chk("wr_port_b", {ram_we_b, ram_addr_b, ram_din_b}, {1'b1, 4'd7, 8'h5A});
      tick(); idle();
      set_req(2, 1'b0, 4'd3, 8'h00); set_req(3, 1'b0, 4'd7, 8'h00); #1;
      chk("rd_ready", req_ready, 4'b1100);
      chk("rd_port_a", {ram_we_a, ram_addr_a}, {1'b0, 4'd3});
      chk("rd_port_b", {ram_we_b, ram_addr_b}, {1'b0, 4'd7});
      tick(); idle(); #1;
      chk("rd_rsp_valid", rsp_valid, 4'b1100);
      chk("rd_rsp2", rd(2), 8'hA5);
      chk("rd_rsp3", rd(3), 8'h5A);
      tick();
      chk("rd_pulse_end", rsp_valid, 4'h0);
      chk("rd_hold2", rd(2), 8'hA5);
      // write/read conflict at rr_ptr=0
      set_req(0, 1'b1, 4'd5, 8'h3C); set_req(1, 1'b0, 4'd5, 8'h00); #1;
      chk("cf_ready", req_ready, 4'b0001);
      chk("cf_port_a", {ram_we_a, ram_addr_a, ram_din_a}, {1'b1, 4'd5, 8'h3C});
      chk("cf_port_b_idle", {ram_we_b, ram_addr_b, ram_din_b}, 13'h0);
      tick();
      chk("cf_cnt1", conflict_cnt, 4'd1);
      idle(); set_req(1, 1'b0, 4'd5, 8'h00); #1;
      chk("cf_retry_ready", req_ready, 4'b0010);
      chk("cf_retry_port_a", {ram_we_a, ram_addr_a}, {1'b0, 4'd5});
      tick(); idle(); #1;
      chk("cf_rsp_valid", rsp_valid, 4'b0010);
      chk("cf_rsp1", rd(1), 8'h3C);
      // single read from req3 brings rr_ptr back to 0
      set_req(3, 1'b0, 4'd7, 8'h00); #1;
      chk("single_ready", req_ready, 4'b1000);
      chk("single_port", {ram_addr_a, ram_addr_b}, {4'd7, 4'd0});
      tick(); idle();
      chk("single_rsp", {rsp_valid, rd(3)}, {4'b1000, 8'h5A});
      // all four reading continuously
      set_req(0, 1'b0, 4'd3, 8'h00); set_req(1, 1'b0, 4'd7, 8'h00);
      set_req(2, 1'b0, 4'd5, 8'h00); set_req(3, 1'b0, 4'd0, 8'h00); #1;
      chk("rot0_ready", req_ready, 4'b0011);
      tick();
      chk("rot1_ready", req_ready, 4'b1100);
      chk("rot1_rsp", {rsp_valid, rd(1), rd(0)}, {4'b0011, 8'h5A, 8'hA5});
      tick();
      chk("rot2_ready", req_ready, 4'b0011);
      chk("rot2_rsp", {rsp_valid, rd(3), rd(2)}, {4'b1100, 8'h00, 8'h3C});
      tick();
      chk("rot3_ready", req_ready, 4'b1100);
      chk("rot3_rsp", rsp_valid, 4'b0011);
      tick(); idle(); #1;
      chk("rot4_rsp", rsp_valid, 4'b1100);
      chk("rot_cnt", conflict_cnt, 4'd1);
      // read/read to the same address is not a conflict
      set_req(0, 1'b0, 4'd3, 8'h00); set_req(1, 1'b0, 4'd3, 8'h00); #1;
      chk("rr_same_ready", req_ready, 4'b0011);
      tick(); idle(); #1;
      chk("rr_same_rsp", {rsp_valid, rd(1), rd(0)}, {4'b0011, 8'hA5, 8'hA5});
      chk("rr_same_cnt", conflict_cnt, 4'd1);
      // reset right after a read grant drops the response
      set_req(2, 1'b0, 4'd3, 8'h00); #1;
      chk("rst_mid_ready", req_ready, 4'b0100);
      tick(); idle(); rst_n = 1'b0; #1;
      chk("rst_mid_rsp_valid", rsp_valid, 4'h0);
      chk("rst_mid_rsp_data", rsp_data, 32'h0);
      chk("rst_mid_cnt", conflict_cnt, 4'd0);
      tick(); rst_n = 1'b1; tick();
      chk("rst_post_rsp_valid", rsp_valid, 4'h0);
      set_req(1, 1'b0, 4'd3, 8'h00); set_req(2, 1'b0, 4'd7, 8'h00); set_req(3, 1'b0, 4'd5, 8'h00); #1;
      chk("rst_ptr_zero", req_ready, 4'b0110);
      idle();
      // persistent write/write conflict saturates the counter
      set_req(0, 1'b1, 4'd9, 8'h11); set_req(1, 1'b1, 4'd9, 8'h22); #1;
      chk("sat_ready", req_ready, 4'b0001);
      tick();
      chk("sat_cnt1", conflict_cnt, 4'd1);
      for (int k = 0; k < 14; k++) tick();
      chk("sat_cnt15", conflict_cnt, 4'd15);
      for (int k = 0; k < 3; k++) tick();
      chk("sat_cnt_hold", conflict_cnt, 4'd15);
      idle(); tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
